// File: rtl/redun_mont_carry_resolve_pkg.sv
// redun_mont_carry_resolve_pkg: shared word/field types for the redundant Montgomery datapath
package redun_mont_carry_resolve_pkg;
    localparam int WRD_BITS     = 32;
    localparam int NUM_WRDS     = 33;
    localparam int DAT_BITS     = NUM_WRDS * WRD_BITS;
    localparam int WRDS_PER_CYC = 3;

    typedef logic [WRD_BITS:0]                   redun_wrd_t;
    typedef redun_wrd_t [NUM_WRDS-1:0]           redun0_t;
    typedef logic [DAT_BITS-1:0]                 fe_t;
    typedef logic [1:0]                          carry_t;
    typedef redun_wrd_t [WRDS_PER_CYC-1:0]       redun_chunk_t;

    function automatic logic [DAT_BITS:0] from_redun(input redun0_t d);
        logic [DAT_BITS:0] s;
        s = '0;
        for (int j = 0; j < NUM_WRDS; j++) s = s + ((DAT_BITS+1)'(d[j]) << (j * WRD_BITS));
        return s;
    endfunction

    // Only bit DAT_BITS is visible here; a carry of 2 out of the top word is missed.
    function automatic logic check_overflow(input redun0_t d);
        logic [DAT_BITS:0] s;
        s = from_redun(d);
        return s[DAT_BITS];
    endfunction
endpackage

// File: rtl/redun_carry_chunk.sv
// redun_carry_chunk: resolves one chunk of redundant words against an incoming carry
module redun_carry_chunk
    import redun_mont_carry_resolve_pkg::*;
#(
    parameter int W = WRD_BITS,
    parameter int N = WRDS_PER_CYC
) (
    input  logic [N-1:0][W:0] chunk,
    input  carry_t            carry_in,
    output logic [N*W-1:0]    res,
    output carry_t            carry_out
);
    // A (W+1)-bit word plus a carry of at most 2 never exceeds 2^(W+1)+1, so the carry stays below 3.
    always_comb begin
        carry_t       c;
        logic [W+1:0] s;
        c   = carry_in;
        s   = '0;
        res = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, chunk[k]} + {{W{1'b0}}, c};
            res[k*W +: W] = s[W-1:0];
            c = s[W+1:W];
        end
        carry_out = c;
    end
endmodule

// File: rtl/redun_mont_carry_resolve.sv
// redun_mont_carry_resolve: word-serial carry resolution of a redundant value into a canonical field element
module redun_mont_carry_resolve
    import redun_mont_carry_resolve_pkg::*;
#(
    parameter int WRD_BITS     = redun_mont_carry_resolve_pkg::WRD_BITS,
    parameter int NUM_WRDS     = redun_mont_carry_resolve_pkg::NUM_WRDS,
    parameter int WRDS_PER_CYC = redun_mont_carry_resolve_pkg::WRDS_PER_CYC
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_WRDS-1:0][WRD_BITS:0]  i_dat,
    input  logic                             i_val,
    output logic                             o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]     o_dat,
    output logic                             o_ovf,
    output logic                             o_val,
    input  logic                             i_rdy
);
    localparam int NUM_CHUNKS = NUM_WRDS / WRDS_PER_CYC;
    localparam int CHUNK_BITS = WRDS_PER_CYC * WRD_BITS;
    localparam int SHIFT      = WRDS_PER_CYC * (WRD_BITS + 1);
    localparam int IDX_BITS   = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROP = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    if (NUM_WRDS % WRDS_PER_CYC != 0) begin : g_bad_cfg
        $error("WRDS_PER_CYC must divide NUM_WRDS");
    end

    logic [1:0]                            state;
    logic [IDX_BITS-1:0]                   idx;
    logic [NUM_WRDS-1:0][WRD_BITS:0]       dat_q;
    carry_t                                carry;
    carry_t                                carry_nxt;
    logic [CHUNK_BITS-1:0]                 res;
    logic [WRDS_PER_CYC-1:0][WRD_BITS:0]   chunk;

    assign o_rdy = (state == IDLE) & ~i_rst;
    // The input register shifts down one chunk per cycle, so the low chunk is always the next one.
    assign chunk = dat_q[WRDS_PER_CYC-1:0];

    redun_carry_chunk #(.W(WRD_BITS), .N(WRDS_PER_CYC)) u_chunk (
        .chunk     (chunk),
        .carry_in  (carry),
        .res       (res),
        .carry_out (carry_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            idx   <= '0;
            dat_q <= '0;
            carry <= '0;
            o_dat <= '0;
            o_ovf <= 1'b0;
            o_val <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_val) begin
                    state <= PROP;
                    dat_q <= i_dat;
                    idx   <= '0;
                    carry <= '0;
                    o_dat <= '0;
                end
                PROP: begin
                    dat_q <= dat_q >> SHIFT;
                    o_dat[idx*CHUNK_BITS +: CHUNK_BITS] <= res;
                    carry <= carry_nxt;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_BITS'(NUM_CHUNKS - 1)) state <= OUT;
                end
                // First OUT cycle folds the final carry into the overflow flag, then o_val is raised.
                OUT: if (!o_val) begin
                    o_val <= 1'b1;
                    o_ovf <= |carry;
                end else if (i_rdy) begin
                    o_val <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
